// File: rtl/matrix_gen_engine.sv
// -----------------------------------------------------------------------------
// matrix_gen_engine: batch random-matrix generator (check/alloc/fill/commit).
// Optional echo stream enabled by GEN_ECHO_EN.                        Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module matrix_gen_engine #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 9,
  parameter int DIM_WIDTH     = 5,
  parameter int COUNT_WIDTH   = 4,
  parameter int SLOT_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [COUNT_WIDTH-1:0]   cmd_count,
  input  logic [DIM_WIDTH-1:0]     cmd_m,
  input  logic [DIM_WIDTH-1:0]     cmd_n,
  input  logic [ELEMENT_WIDTH-1:0] cmd_min,
  input  logic [ELEMENT_WIDTH-1:0] cmd_max,
  input  logic [DIM_WIDTH-1:0]     cfg_max_dim,
  input  logic [COUNT_WIDTH-1:0]   cfg_max_count,
  input  logic                     seed_load,
  input  logic [15:0]              seed_value,
  output logic                     alloc_req,
  output logic [DIM_WIDTH-1:0]     alloc_m,
  output logic [DIM_WIDTH-1:0]     alloc_n,
  input  logic                     alloc_valid,
  input  logic                     alloc_fail,
  input  logic [SLOT_WIDTH-1:0]    alloc_slot,
  input  logic [ADDR_WIDTH-1:0]    alloc_addr,
  output logic                     commit_req,
  output logic [SLOT_WIDTH-1:0]    commit_slot,
  output logic [DIM_WIDTH-1:0]     commit_m,
  output logic [DIM_WIDTH-1:0]     commit_n,
  output logic [ADDR_WIDTH-1:0]    commit_addr,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               error_code,
  output logic [COUNT_WIDTH-1:0]   gen_index
`ifdef GEN_ECHO_EN
  ,
  output logic                     echo_valid,
  output logic [ELEMENT_WIDTH-1:0] echo_data,
  output logic                     echo_last,
  input  logic                     echo_ready
`endif
);

  localparam int c_TW = 2 * DIM_WIDTH;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_CHECK  = 3'd1;
  localparam logic [2:0] c_ST_ALLOC  = 3'd2;
  localparam logic [2:0] c_ST_FILL   = 3'd3;
  localparam logic [2:0] c_ST_COMMIT = 3'd4;
  localparam logic [2:0] c_ST_FINISH = 3'd5;

  localparam logic [2:0] c_ERR_NONE  = 3'd0;
  localparam logic [2:0] c_ERR_DIM   = 3'd1;
  localparam logic [2:0] c_ERR_COUNT = 3'd2;
  localparam logic [2:0] c_ERR_VALUE = 3'd3;
  localparam logic [2:0] c_ERR_ALLOC = 3'd4;

  localparam logic [15:0] c_LFSR_INIT = 16'hACE1;
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

  logic [2:0]               r_state;
  logic [15:0]              r_lfsr;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic [DIM_WIDTH-1:0]     r_m;
  logic [DIM_WIDTH-1:0]     r_n;
  logic [ELEMENT_WIDTH-1:0] r_min;
  logic [ELEMENT_WIDTH-1:0] r_max;
  logic [ELEMENT_WIDTH-1:0] r_span;
  logic [ELEMENT_WIDTH-1:0] r_mask;
  logic [c_TW-1:0]          r_total;
  logic [c_TW-1:0]          r_idx;
  logic [SLOT_WIDTH-1:0]    r_slot;
  logic [ADDR_WIDTH-1:0]    r_base;
  logic [2:0]               r_err;
  logic [COUNT_WIDTH-1:0]   r_gidx;

  logic [15:0]              w_lfsr_next;
  logic [ELEMENT_WIDTH-1:0] w_span;
  logic [c_TW-1:0]          w_total;
  logic [c_TW-1:0]          w_idx_inc;
  logic [COUNT_WIDTH-1:0]   w_gidx_inc;
  logic [ELEMENT_WIDTH-1:0] w_cand;
  logic [ELEMENT_WIDTH-1:0] w_wr_data;
  logic [ADDR_WIDTH-1:0]    w_wr_addr;
  logic                     w_dim_err;
  logic                     w_cnt_err;
  logic                     w_echo_free;
  logic                     w_wr;
  logic                     w_last;
  logic                     w_in_alloc;
  logic                     w_in_commit;

  // Smallest all-ones mask covering v: OR of v with every right shift of itself.
  function automatic logic [ELEMENT_WIDTH-1:0] f_fill_ones(input logic [ELEMENT_WIDTH-1:0] v);
    logic [ELEMENT_WIDTH-1:0] acc;
    acc = v;
    for (int i = 1; i < ELEMENT_WIDTH; i++) begin
      acc = acc | (v >> i);
    end
    return acc;
  endfunction

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_LFSR_TAPS) : (r_lfsr >> 1);
  assign w_span      = r_max - r_min;
  assign w_total     = c_TW'(r_m) * c_TW'(r_n);
  assign w_idx_inc   = r_idx + c_TW'(1);
  assign w_gidx_inc  = r_gidx + COUNT_WIDTH'(1);
  assign w_cand      = r_lfsr[ELEMENT_WIDTH-1:0] & r_mask;
  assign w_wr_data   = r_min + w_cand;
  assign w_wr_addr   = r_base + ADDR_WIDTH'(r_idx);
  assign w_last      = (w_idx_inc == r_total);
  assign w_dim_err   = (r_m == '0) || (r_n == '0) || (r_m > cfg_max_dim) || (r_n > cfg_max_dim);
  assign w_cnt_err   = (r_count == '0) || (r_count > cfg_max_count);
  assign w_in_alloc  = (r_state == c_ST_ALLOC);
  assign w_in_commit = (r_state == c_ST_COMMIT) && w_echo_free;
  assign w_wr        = (r_state == c_ST_FILL) && (w_cand <= r_span) && w_echo_free;

`ifdef GEN_ECHO_EN
  logic                     r_echo_valid;
  logic [ELEMENT_WIDTH-1:0] r_echo_data;
  logic                     r_echo_last;

  // The echo slot frees either when empty or when accepted this very cycle.
  assign w_echo_free = echo_ready || !r_echo_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_echo_valid <= 1'b0;
      r_echo_data  <= '0;
      r_echo_last  <= 1'b0;
    end else if (w_wr) begin
      r_echo_valid <= 1'b1;
      r_echo_data  <= w_wr_data;
      r_echo_last  <= w_last;
    end else if (echo_ready) begin
      r_echo_valid <= 1'b0;
    end
  end

  assign echo_valid = r_echo_valid;
  assign echo_data  = r_echo_data;
  assign echo_last  = r_echo_last;
`else
  assign w_echo_free = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= c_LFSR_INIT;
    end else if (seed_load) begin
      r_lfsr <= (seed_value == 16'd0) ? c_LFSR_INIT : seed_value;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_count <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_span  <= '0;
      r_mask  <= '0;
      r_total <= '0;
      r_idx   <= '0;
      r_slot  <= '0;
      r_base  <= '0;
      r_err   <= c_ERR_NONE;
      r_gidx  <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (cmd_valid) begin
            r_count <= cmd_count;
            r_m     <= cmd_m;
            r_n     <= cmd_n;
            r_min   <= cmd_min;
            r_max   <= cmd_max;
            r_err   <= c_ERR_NONE;
            r_gidx  <= '0;
            r_state <= c_ST_CHECK;
          end
        end
        c_ST_CHECK: begin
          if (w_dim_err) begin
            r_err   <= c_ERR_DIM;
            r_state <= c_ST_FINISH;
          end else if (w_cnt_err) begin
            r_err   <= c_ERR_COUNT;
            r_state <= c_ST_FINISH;
          end else if (r_min > r_max) begin
            r_err   <= c_ERR_VALUE;
            r_state <= c_ST_FINISH;
          end else begin
            r_total <= w_total;
            r_span  <= w_span;
            r_mask  <= f_fill_ones(w_span);
            r_state <= c_ST_ALLOC;
          end
        end
        c_ST_ALLOC: begin
          if (alloc_fail) begin
            r_err   <= c_ERR_ALLOC;
            r_state <= c_ST_FINISH;
          end else if (alloc_valid) begin
            r_slot  <= alloc_slot;
            r_base  <= alloc_addr;
            r_idx   <= '0;
            r_state <= c_ST_FILL;
          end
        end
        c_ST_FILL: begin
          if (w_wr) begin
            r_idx <= w_idx_inc;
            if (w_last) begin
              r_state <= c_ST_COMMIT;
            end
          end
        end
        c_ST_COMMIT: begin
          if (w_echo_free) begin
            r_gidx  <= w_gidx_inc;
            r_state <= (w_gidx_inc < r_count) ? c_ST_ALLOC : c_ST_FINISH;
          end
        end
        c_ST_FINISH: r_state <= c_ST_IDLE;
        default:     r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Data outputs are zeroed outside their strobes so idle buses stay quiet.
  assign cmd_ready   = (r_state == c_ST_IDLE);
  assign busy        = (r_state != c_ST_IDLE);
  assign done        = (r_state == c_ST_FINISH);
  assign alloc_req   = w_in_alloc;
  assign alloc_m     = w_in_alloc ? r_m : '0;
  assign alloc_n     = w_in_alloc ? r_n : '0;
  assign commit_req  = w_in_commit;
  assign commit_slot = w_in_commit ? r_slot : '0;
  assign commit_m    = w_in_commit ? r_m : '0;
  assign commit_n    = w_in_commit ? r_n : '0;
  assign commit_addr = w_in_commit ? r_base : '0;
  assign mem_wr_en   = w_wr;
  assign mem_wr_addr = w_wr ? w_wr_addr : '0;
  assign mem_wr_data = w_wr ? w_wr_data : '0;
  assign error_code  = r_err;
  assign gen_index   = r_gidx;

endmodule

`default_nettype wire

// File: tb/tb_matrix_gen_engine.sv
// -----------------------------------------------------------------------------
// tb_matrix_gen_engine: scoreboard bench for matrix_gen_engine (default build).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_matrix_gen_engine;
  localparam int EW = 8, AW = 9, DW = 5, CW = 4, SW = 4;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, seed_load;
  logic [CW-1:0] cmd_count, cfg_max_count, gen_index;
  logic [DW-1:0] cmd_m, cmd_n, cfg_max_dim, alloc_m, alloc_n, commit_m, commit_n;
  logic [EW-1:0] cmd_min, cmd_max, mem_wr_data;
  logic [15:0]   seed_value;
  logic          alloc_req, alloc_valid, alloc_fail, commit_req, mem_wr_en, busy, done;
  logic [SW-1:0] alloc_slot, commit_slot;
  logic [AW-1:0] alloc_addr, commit_addr, mem_wr_addr;
  logic [2:0]    error_code;

  always #5 clk = ~clk;

  matrix_gen_engine dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_min(cmd_min), .cmd_max(cmd_max),
    .cfg_max_dim(cfg_max_dim), .cfg_max_count(cfg_max_count),
    .seed_load(seed_load), .seed_value(seed_value),
    .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
    .alloc_valid(alloc_valid), .alloc_fail(alloc_fail), .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
    .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m), .commit_n(commit_n),
    .commit_addr(commit_addr), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .error_code(error_code), .gen_index(gen_index)
  );

  typedef struct { logic fail; logic [SW-1:0] slot; logic [AW-1:0] addr; } alloc_t;
  typedef struct { logic [SW-1:0] slot; logic [DW-1:0] m; logic [DW-1:0] n; logic [AW-1:0] addr; } commit_t;
  typedef struct { logic [2:0] err; logic [CW-1:0] gidx; } done_t;

  alloc_t        q_alloc[$];
  commit_t       q_commit[$];
  done_t         q_done[$];
  logic [AW-1:0] q_wr[$];

  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0, wr_cnt = 0, first_wr = 0, last_wr = 0, lat = 0;
  logic [15:0]   lfsr_m;
  logic [EW-1:0] exp_min, exp_span, exp_mask, cand;
  logic [DW-1:0] cur_m, cur_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int exp_err(input int c, m, n, mn, mx, md, mc);
    if (m == 0 || n == 0 || m > md || n > md) return 1;
    if (c == 0 || c > mc) return 2;
    if (mn > mx) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) lfsr_m <= 16'hACE1;
    else if (seed_load) lfsr_m <= (seed_value == 16'd0) ? 16'hACE1 : seed_value;
    else lfsr_m <= lfsr_adv(lfsr_m);
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write, commit or done.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en) begin
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
        if (q_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected actual_addr=%0h required=no_write", mem_wr_addr);
        end else begin
          cand = lfsr_m[EW-1:0] & exp_mask;
          check("wr_addr", 64'(mem_wr_addr), 64'(q_wr.pop_front()));
          check("wr_accept", 64'(cand <= exp_span), 64'd1);
          check("wr_data", 64'(mem_wr_data), 64'(exp_min + cand));
        end
      end
      if (commit_req) begin
        if (q_commit.size() == 0) begin
          checks++; failures++;
          $display("FAIL commit_unexpected actual=1 required=0");
        end else begin
          commit_t c;
          c = q_commit.pop_front();
          check("commit_fields", 64'({commit_slot, commit_m, commit_n, commit_addr}),
                64'({c.slot, c.m, c.n, c.addr}));
        end
      end
      if (done) begin
        done_cyc = cyc;
        if (q_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected actual=1 required=0");
        end else begin
          done_t d;
          d = q_done.pop_front();
          check("done_error_code", 64'(error_code), 64'(d.err));
          check("done_gen_index", 64'(gen_index), 64'(d.gidx));
        end
      end
    end
  end

  // Allocation responder: answers each request from the scripted queue after a random delay.
  initial begin
    alloc_t a;
    alloc_valid = 1'b0; alloc_fail = 1'b0; alloc_slot = '0; alloc_addr = '0;
    forever begin
      @(negedge clk);
      alloc_valid = 1'b0; alloc_fail = 1'b0;
      if (!rst && alloc_req) begin
        if (q_alloc.size() == 0) begin
          checks++; failures++;
          $display("FAIL alloc_unexpected actual=1 required=0");
          alloc_fail = 1'b1;
        end else if (lat > 0) begin
          lat--;
        end else begin
          a = q_alloc.pop_front();
          check("alloc_dims", 64'({alloc_m, alloc_n}), 64'({cur_m, cur_n}));
          alloc_valid = 1'b1;           // also high with a refusal: refusal must win
          alloc_fail  = a.fail;
          alloc_slot  = a.slot;
          alloc_addr  = a.addr;
          lat = $urandom_range(0, 2);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, 64'({cmd_ready, busy, done, alloc_req, commit_req, mem_wr_en, error_code, gen_index}),
          64'({1'b1, 5'b0, 3'd0, 4'd0}));
    check({name, "_data"}, 64'({mem_wr_addr, mem_wr_data, alloc_m, alloc_n, commit_slot, commit_m, commit_n, commit_addr}),
          64'd0);
  endtask

  task automatic start_cmd(input int cnt, m, n, mn, mx, md, mc, fail_at, base, output int err);
    int gidx, tot, sp, mk, b;
    alloc_t a;
    err = exp_err(cnt, m, n, mn, mx, md, mc);
    gidx = 0; tot = m * n; sp = mx - mn; mk = 0;
    while (mk < sp) mk = mk * 2 + 1;
    if (err == 0) begin
      for (int g = 0; g < cnt; g++) begin
        b = (base < 0) ? int'($urandom_range(0, 511)) : (base + g * tot) % 512;
        a.fail = (g == fail_at); a.slot = SW'(g + 3); a.addr = AW'(b);
        q_alloc.push_back(a);
        if (a.fail) begin err = 4; break; end
        for (int i = 0; i < tot; i++) q_wr.push_back(AW'((b + i) % 512));
        q_commit.push_back('{a.slot, DW'(m), DW'(n), a.addr});
        gidx++;
      end
    end
    q_done.push_back('{3'(err), CW'(gidx)});
    exp_min = EW'(mn); exp_span = EW'(sp); exp_mask = EW'(mk);
    cur_m = DW'(m); cur_n = DW'(n);
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_count = CW'(cnt); cmd_m = DW'(m); cmd_n = DW'(n);
    cmd_min = EW'(mn); cmd_max = EW'(mx); cfg_max_dim = DW'(md); cfg_max_count = CW'(mc);
    acc_cyc = cyc; wr_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", 64'({busy, cmd_ready}), 64'(2'b10));
  endtask

  task automatic finish_cmd(input int err);
    for (int i = 0; i < 5000 && q_done.size() != 0; i++) @(posedge clk);
    if (q_done.size() != 0) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done");
      q_done.delete(); q_wr.delete(); q_commit.delete(); q_alloc.delete();
    end
    check("writes_all_seen", 64'(q_wr.size()), 64'd0);
    check("commits_all_seen", 64'(q_commit.size()), 64'd0);
    check("allocs_all_used", 64'(q_alloc.size()), 64'd0);
    if (err >= 1 && err <= 3) check("err_done_latency", 64'(done_cyc - acc_cyc), 64'd2);
  endtask

  task automatic run_cmd(input int cnt, m, n, mn, mx, md, mc, fail_at, base);
    int err;
    start_cmd(cnt, m, n, mn, mx, md, mc, fail_at, base, err);
    finish_cmd(err);
  endtask

  initial begin
    int err;
    rst = 1'b1; cmd_valid = 1'b0; cmd_count = '0; cmd_m = '0; cmd_n = '0; cmd_min = '0; cmd_max = '0;
    cfg_max_dim = 5'd16; cfg_max_count = 4'd4; seed_load = 1'b0; seed_value = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;

    run_cmd(2, 2, 3, 0, 9, 16, 4, -1, 'h040);
    run_cmd(1, 3, 3, 7, 7, 16, 4, -1, 'h100);
    check("const_write_count", 64'(wr_cnt), 64'd9);
    check("const_write_back_to_back", 64'(last_wr - first_wr), 64'd8);
    run_cmd(1, 17, 3, 0, 9, 16, 4, -1, 0);
    run_cmd(1, 2, 2, 12, 3, 16, 4, -1, 0);
    run_cmd(5, 2, 2, 0, 9, 16, 4, -1, 0);
    run_cmd(3, 2, 2, 0, 50, 16, 4, 1, -1);
    run_cmd(1, 2, 3, 5, 20, 16, 4, -1, -1);
    run_cmd(1, 2, 2, 0, 255, 16, 4, -1, 'h1FE);
    run_cmd(4, 4, 4, 100, 131, 4, 4, -1, -1);

    @(negedge clk); seed_load = 1'b1; seed_value = 16'($urandom);
    @(negedge clk); seed_load = 1'b0;

    for (int k = 0; k < 10; k++) begin
      int cnt, m, n, mn, mx, md, mc, fa;
      cnt = $urandom_range(0, 4); m = $urandom_range(0, 5); n = $urandom_range(0, 5);
      md = $urandom_range(3, 16); mc = $urandom_range(2, 4); mn = $urandom_range(0, 255);
      mx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : mn + int'($urandom_range(0, 255 - mn));
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt)) : -1;
      run_cmd(cnt, m, n, mn, mx, md, mc, fa, -1);
    end

    // Reset in the middle of FILL with a zero seed requested at the same time.
    start_cmd(1, 4, 4, 0, 200, 16, 4, -1, 'h100, err);
    for (int i = 0; i < 300 && wr_cnt < 3; i++) @(negedge clk);
    check("fill_progress_before_rst", 64'(wr_cnt >= 3), 64'd1);
    rst = 1'b1; seed_load = 1'b1; seed_value = 16'h0000;
    @(negedge clk);
    rst = 1'b0; seed_load = 1'b0;
    q_wr.delete(); q_commit.delete(); q_done.delete(); q_alloc.delete(); lat = 0;
    check_reset_outputs("mid_fill_reset");
    repeat (4) @(negedge clk);
    run_cmd(1, 3, 2, 10, 40, 16, 4, -1, 'h020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/matrix_gen_engine.md
Name: matrix_gen_engine

Overview:
Parametrised successor to the UART-driven generate mode. It accepts a binary generation command (count, m×n, value range) over a valid/ready handshake and runs the batch without further commands. For each matrix it allocates, fills with pseudo-random values in [min,max] from an internal LFSR, then commits. It sits between the mode controller/UART parser and the matrix manager and BRAM write port. Display is left to downstream blocks.

Parameters:
ELEMENT_WIDTH, 8, element data width (min 4)
ADDR_WIDTH, 9, BRAM address width
DIM_WIDTH, 5, width of m/n fields (max dim 2^DIM_WIDTH-1)
COUNT_WIDTH, 4, width of matrices-per-command field
SLOT_WIDTH, 4, matrix manager slot id width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_count  in  COUNT_WIDTH  matrices to generate
cmd_m, cmd_n  in  DIM_WIDTH  each; dimensions
cmd_min, cmd_max  in  ELEMENT_WIDTH  each; inclusive value range
cfg_max_dim  in  DIM_WIDTH  dimension limit
cfg_max_count  in  COUNT_WIDTH  count limit
seed_load  in  1  load LFSR seed (any state)
seed_value  in  16  seed
alloc_req  out  1  allocation request, level until response
alloc_m, alloc_n  out  DIM_WIDTH  each; requested dims
alloc_valid  in  1  allocation granted
alloc_fail  in  1  allocation refused
alloc_slot  in  SLOT_WIDTH  granted slot
alloc_addr  in  ADDR_WIDTH  granted base address
commit_req  out  1  one-cycle commit pulse
commit_slot  out  SLOT_WIDTH  slot to commit
commit_m, commit_n  out  DIM_WIDTH  each
commit_addr  out  ADDR_WIDTH  base address
mem_wr_en  out  1  BRAM write strobe
mem_wr_addr  out  ADDR_WIDTH  write address
mem_wr_data  out  ELEMENT_WIDTH  write data
busy  out  1  not in IDLE
done  out  1  one-cycle pulse at batch end (success or error)
error_code  out  3  0 none, 1 dim range, 2 count range, 3 value range, 4 alloc fail
gen_index  out  COUNT_WIDTH  matrices completed in the current batch

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State IDLE. LFSR=16'hACE1. error_code holds until next accepted command.
- LFSR: 16-bit Galois, mask 16'hB400, advances every cycle. seed_load has priority; seed 0 loads 16'hACE1.
- IDLE: on cmd_valid, latch all cmd_* fields and clear error_code and gen_index. Go to CHECK.
- CHECK (1 cycle), errors tested in this order:
  - m or n = 0, or m or n > cfg_max_dim -> code 1.
  - count = 0 or count > cfg_max_count -> code 2.
  - min > max -> code 3.
  - On any error go to FINISH. Otherwise compute total=m*n (2*DIM_WIDTH bits), span=max-min, mask=smallest 2^k-1 ≥ span. Go to ALLOC.
- ALLOC: alloc_req=1 with alloc_m/n. On alloc_valid: latch slot and addr, idx=0, go to FILL. On alloc_fail: code 4, go to FINISH. If both are asserted, alloc_fail wins.
- FILL: each cycle, cand = LFSR[ELEMENT_WIDTH-1:0] & mask.
  - If cand ≤ span: mem_wr_en=1, addr=base+idx (row-major, mod 2^ADDR_WIDTH), data=min+cand, idx++.
  - Otherwise no write that cycle (rejection, retried next cycle).
  - After the write with idx=total-1, go to COMMIT.
- COMMIT: commit_req=1 for exactly 1 cycle with latched slot/m/n/addr. gen_index++. If gen_index+1 < count go to ALLOC, else go to FINISH.
- FINISH: done=1 for 1 cycle, go to IDLE.
- No write ever occurs outside FILL, and no commit occurs after an error.
- Matrices already committed in a batch remain committed if a later alloc fails.
- rst mid-batch aborts immediately: no commit, no done pulse. Partially written BRAM contents are don't-care.

Optional Feature:
GEN_ECHO_EN
- Defined: adds echo_valid (out,1), echo_data (out,ELEMENT_WIDTH), echo_last (out,1) and echo_ready (in,1).
- In FILL, a write occurs only when cand accepts AND (echo_ready or !echo_valid). Each written element is also presented on echo_data with echo_valid, held until echo_ready.
- echo_last marks the final element of each matrix.
- COMMIT waits until the final echo is accepted.
- Undefined: these ports are absent and FILL never stalls on them.

Test Plan:
- cmd count=2,m=2,n=3,min=0,max=9, cfg_max_dim=16, cfg_max_count=4, alloc_valid with addr 0x040 then 0x046 -> 6 writes each to 0x040–0x045 and 0x046–0x04B, all data in 0..9, 2 commit pulses with m=2,n=3, gen_index=2, done, error 0.
- min=max=7, 3x3 -> 9 consecutive-cycle writes all =7, exactly 9 FILL cycles.
- m=17 with cfg_max_dim=16 -> error 1, done after 2 cycles, no alloc_req.
- min=12,max=3 -> error 3; count=5 with cfg_max_count=4 -> error 2.
- count=3, second allocation answered alloc_fail -> exactly 1 commit, error 4, done; next command is accepted normally.
- rst asserted during FILL -> next cycle all outputs at reset values, cmd_ready=1; with seed_load=1, seed=0 the LFSR equals 16'hACE1 next cycle.
